// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot decode pipeline.
// Holds the skid state, the stored-word layout and the index-width function.
package onehot_pkg;

    function automatic int unsigned onehot_bin_w(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned OH_W_DEF  = 16;
    localparam int unsigned BIN_W_DEF = onehot_bin_w(OH_W_DEF);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [BIN_W_DEF-1:0] bin;
        logic                 err;
    } onehot_word_t;

endpackage

// File: rtl/onehot_encode_chk.sv
// Combinational one-hot legality check and binary encode.
// Lowest set index wins when several bits are set; zero maps to index 0.
module onehot_encode_chk
    import onehot_pkg::*;
#(
    parameter int unsigned ONE_HOT_W = OH_W_DEF,
    localparam int unsigned BIN_W    = onehot_bin_w(ONE_HOT_W)
) (
    input  logic [ONE_HOT_W-1:0] one_hot_i,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 err_o
);

    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        bin_o = '0;
        for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
            if (one_hot_i[i]) begin
                bin_o = BIN_W'(i);
            end
        end
    end

    // Illegal when empty or when clearing the lowest bit leaves any bit set.
    always_comb begin
        err_o = (one_hot_i == '0) ||
                ((one_hot_i & (one_hot_i - ONE_HOT_W'(1))) != '0);
    end

endmodule

// File: rtl/one_hot_to_binary_pipe.sv
// One-hot to binary re-encoder behind a 2-entry skid buffer.
// in_ready_o is registered; illegal accepted words bump a saturating counter.
module one_hot_to_binary_pipe
    import onehot_pkg::*;
#(
    parameter int unsigned ONE_HOT_W = OH_W_DEF,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned BIN_W    = onehot_bin_w(ONE_HOT_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ONE_HOT_W-1:0] one_hot_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    input  logic                 clr_cnt_i
);

    skid_state_e          state_q, state_d;
    onehot_word_t         out_q, out_d;
    onehot_word_t         skid_q, skid_d;
    logic                 ready_q, ready_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    onehot_word_t enc;
    logic         accept;
    logic         xfer;

    onehot_encode_chk #(
        .ONE_HOT_W (ONE_HOT_W)
    ) u_enc (
        .one_hot_i (one_hot_i),
        .bin_o     (enc.bin),
        .err_o     (enc.err)
    );

    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = ready_q;
    assign bin_o       = out_q.bin;
    assign err_o       = out_q.err;
    assign err_cnt_o   = cnt_q;

    assign accept = in_valid_i && ready_q;
    assign xfer   = out_valid_o && out_ready_i;

    // Skid-buffer next state and register loads.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = enc;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    out_d = enc;
                end else if (xfer) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    skid_d  = enc;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        ready_d = (state_d != FULL);
    end

    // Error counter: clear beats increment, saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (accept && enc.err && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    // State, storage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_one_hot_to_binary_pipe.sv
// Randomized and directed bench for one_hot_to_binary_pipe.
// A queue model of the buffered words checks the DUT on every negedge.
module tb_one_hot_to_binary_pipe;

    localparam int OH_W  = 16;
    localparam int BW    = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [OH_W-1:0] one_hot_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [BW-1:0]   bin_o;
    logic            err_o;
    logic [CW-1:0]   err_cnt_o;
    logic            clr_cnt_i;

    int n_vec;
    int n_err;

    logic [BW:0] mq[$];
    int          mcnt;

    one_hot_to_binary_pipe #(
        .ONE_HOT_W (OH_W),
        .ERR_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .one_hot_i   (one_hot_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .bin_o       (bin_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o),
        .clr_cnt_i   (clr_cnt_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [BW:0] model_enc(input logic [OH_W-1:0] w);
        int ones;
        int low;
        ones = $countones(w);
        low  = 0;
        for (int i = 0; i < OH_W; i++) begin
            if (w[i] && (i < low || !w[low])) low = i;
        end
        if (ones == 0) low = 0;
        return {low[BW-1:0], (ones != 1)};
    endfunction

    // Compare DUT against the queue model, then advance the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic acc, xf;
            logic [BW:0] e;
            check("out_valid", int'(out_valid_o), int'(mq.size() > 0));
            check("in_ready", int'(in_ready_o), int'(mq.size() < 2));
            check("err_cnt", int'(err_cnt_o), mcnt);
            if (mq.size() > 0) begin
                check("bin", int'(bin_o), int'(mq[0][BW:1]));
                check("err", int'(err_o), int'(mq[0][0]));
            end
            acc = in_valid_i && (mq.size() < 2);
            xf  = out_ready_i && (mq.size() > 0);
            e   = model_enc(one_hot_i);
            if (xf) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (clr_cnt_i) mcnt = 0;
            else if (acc && e[0] && mcnt < CMAX) mcnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OH_W-1:0] w);
        in_valid_i = 1'b1;
        one_hot_i  = w;
        step();
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) step();
    endtask

    logic [OH_W-1:0] w;
    int r;

    initial begin
        n_vec = 0;
        n_err = 0;
        mcnt  = 0;
        rst_n = 1'b0;
        in_valid_i  = 1'b0;
        one_hot_i   = '0;
        out_ready_i = 1'b0;
        clr_cnt_i   = 1'b0;
        #12;
        check("rst_valid", int'(out_valid_o), 0);
        check("rst_ready", int'(in_ready_o), 1);
        check("rst_bin", int'(bin_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_cnt", int'(err_cnt_o), 0);
        check("model_enc_0050", int'(model_enc(16'h0050)), (4 << 1) | 1);
        check("model_enc_8000", int'(model_enc(16'h8000)), 15 << 1);
        check("model_enc_0000", int'(model_enc(16'h0000)), 1);
        #2 rst_n = 1'b1;
        step();

        out_ready_i = 1'b1;
        for (int i = 0; i < OH_W; i++) begin
            send(16'h0001 << i);
            check("walk_bin", int'(bin_o), i);
            check("walk_valid", int'(out_valid_o), 1);
        end
        idle(1);
        check("walk_cnt", int'(err_cnt_o), 0);

        out_ready_i = 1'b0;
        send(16'h0008);
        send(16'h0100);
        check("bp_ready_low", int'(in_ready_o), 0);
        check("bp_hold3", int'(bin_o), 3);
        in_valid_i = 1'b1;
        one_hot_i  = 16'h8000;
        step();
        check("bp_still3", int'(bin_o), 3);
        out_ready_i = 1'b1;
        step();
        check("bp_bin8", int'(bin_o), 8);
        step();
        check("bp_bin15", int'(bin_o), 15);
        idle(1);
        check("bp_ready_back", int'(in_ready_o), 1);

        send(16'h0000);
        check("ill0_bin", int'(bin_o), 0);
        check("ill0_err", int'(err_o), 1);
        send(16'h0050);
        check("ill50_bin", int'(bin_o), 4);
        check("ill50_err", int'(err_o), 1);
        idle(1);
        check("ill_cnt2", int'(err_cnt_o), 2);

        repeat (CMAX + 5) send(16'h0000);
        idle(1);
        check("sat_cnt", int'(err_cnt_o), CMAX);
        clr_cnt_i = 1'b1;
        send(16'h0000);
        clr_cnt_i = 1'b0;
        idle(1);
        check("clr_cnt", int'(err_cnt_o), 0);

        out_ready_i = 1'b0;
        send(16'h0003);
        send(16'h0010);
        idle(1);
        check("pre_rst_full", int'(in_ready_o), 0);
        check("pre_rst_cnt", int'(err_cnt_o), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid_o), 0);
        check("mid_rst_ready", int'(in_ready_o), 1);
        check("mid_rst_cnt", int'(err_cnt_o), 0);
        mq.delete();
        mcnt = 0;
        #1 rst_n = 1'b1;
        out_ready_i = 1'b1;
        step();
        send(16'h0004);
        check("post_rst_bin", int'(bin_o), 2);
        idle(2);

        for (int c = 0; c < 10000; c++) begin
            in_valid_i  = ($urandom_range(0, 99) < 60);
            out_ready_i = ($urandom_range(0, 99) < 65);
            clr_cnt_i   = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 99);
            if (r < 5) w = '0;
            else if (r < 10) w = OH_W'($urandom) | OH_W'(16'h0101);
            else w = 16'h0001 << $urandom_range(0, OH_W - 1);
            one_hot_i = w;
            step();
        end
        in_valid_i  = 1'b0;
        clr_cnt_i   = 1'b0;
        out_ready_i = 1'b1;
        repeat (4) step();
        check("drain_empty", int'(out_valid_o), 0);
        check("soak_cnt", int'(err_cnt_o), mcnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
